control: RTL
============

CONTROL -- requirements
Module: control

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port opcode, input, lc3b_opcode, IR opcode field from datapath.
REQ-004 SHALL have port branch_enable, input, 1, nzp compare result from datapath.
REQ-005 SHALL have port mem_resp, input, 1, memory completion strobe for the current read/write.
REQ-006 SHALL have ports load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc, output, 1 each, datapath register loads.
REQ-007 SHALL have ports pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel, output, 1 each, datapath mux selects.
REQ-008 SHALL have port aluop, output, lc3b_aluop, ALU operation.
REQ-009 SHALL have ports mem_read, mem_write, output, 1 each, memory requests; mem_byte_enable, output, 2, fixed 2'b11.

Function
REQ-010 SHALL be a Moore FSM; every output is a function of present state only, except for the listed next-state conditions.
REQ-011 SHALL drive all outputs to 0 and aluop to alu_add in any state that does not set them.
REQ-012 SHALL implement states fetch1, fetch2, fetch3, decode, s_add, s_and, s_not, br, br_taken, calc_addr, ldr1, ldr2, str1, str2.
REQ-013 fetch1 SHALL assert marmux_sel=1, load_mar, pcmux_sel=0, load_pc, and go to fetch2.
REQ-014 fetch2 SHALL assert mem_read, mdrmux_sel=1, load_mdr, and stay until mem_resp=1, then go to fetch3.
REQ-015 fetch3 SHALL assert load_ir and go to decode.
REQ-016 decode SHALL branch on opcode: op_add->s_add, op_and->s_and, op_not->s_not, op_br->br, op_ldr/op_str->calc_addr, any other->fetch1.
REQ-017 s_add/s_and/s_not SHALL assert aluop add/and/not, alumux_sel=0, regfilemux_sel=0, load_regfile, load_cc, then go to fetch1.
REQ-018 br SHALL go to br_taken if branch_enable=1, else to fetch1; br_taken SHALL assert pcmux_sel=1, load_pc, then go to fetch1.
REQ-019 calc_addr SHALL assert aluop=alu_add, alumux_sel=1, storemux_sel=0, marmux_sel=0, load_mar; next is ldr1 for op_ldr, str1 for op_str.
REQ-020 ldr1 SHALL assert mem_read, mdrmux_sel=1, load_mdr, and hold until mem_resp=1, then go to ldr2; ldr2 SHALL assert regfilemux_sel=1, load_regfile, load_cc, then go to fetch1.
REQ-021 str1 SHALL assert storemux_sel=1, aluop=alu_pass, mdrmux_sel=0, load_mdr, then go to str2; str2 SHALL assert mem_write and hold until mem_resp=1, then go to fetch1.
REQ-022 Latency with zero-wait memory (mem_resp high on first request cycle): ADD/AND/NOT 5 cycles; BR 5 not taken, 6 taken; LDR 7; STR 7; each mem_resp-low cycle adds 1.
REQ-023 mem_read and mem_write SHALL never be asserted together; mem_resp outside fetch2/ldr1/str2 SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL force state to fetch1 asynchronously, including during fetch2/ldr1/str2; the request drops immediately.
REQ-025 Outputs during reset SHALL equal fetch1 outputs; the first rising edge after rst_n deasserts SHALL execute fetch1 loads.

Structure
REQ-026 lc3b_opcode, lc3b_aluop, and opcode constants SHALL come from package lc3b_types; the state enum SHALL stay local to control.
REQ-027 SHALL be a single module with no sub-modules: a state register plus combinational output and next-state blocks.

Verification
REQ-028 Reset mid-fetch2 with mem_resp=0 -> state fetch1, mem_read=0, load_mar=1, load_pc=1.
REQ-029 ADD opcode, mem_resp tied 1 -> load_regfile and load_cc high exactly on cycle 5; aluop=alu_add; alumux_sel=0.
REQ-030 BR with branch_enable=1 -> pcmux_sel=1 and load_pc on cycle 6; with branch_enable=0 -> back in fetch1 on cycle 5.
REQ-031 LDR with mem_resp delayed 3 cycles in ldr1 -> mem_read high 4 cycles; then regfilemux_sel=1 and load_regfile for one cycle.
REQ-032 STR -> storemux_sel=1 with aluop=alu_pass in str1; mem_write held until mem_resp; never mem_read and mem_write both 1.
REQ-033 Unused opcode (e.g. op_jmp) at decode -> next state fetch1, with no load_regfile, load_cc, or mem_write.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b field types: IR opcode encoding and ALU operation select.
package lc3b_types;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'b000,
        alu_and  = 3'b001,
        alu_not  = 3'b010,
        alu_pass = 3'b011,
        alu_sll  = 3'b100,
        alu_srl  = 3'b101,
        alu_sra  = 3'b110
    } lc3b_aluop;

endpackage

// File: rtl/control.sv
// LC-3b multicycle control unit: Moore FSM sequencing fetch, decode and
// execute of ADD/AND/NOT/BR/LDR/STR; outputs depend on the present state only.
module control
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_opcode opcode,
    input  logic       branch_enable,
    input  logic       mem_resp,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_cc,
    output logic       pcmux_sel,
    output logic       storemux_sel,
    output logic       alumux_sel,
    output logic       regfilemux_sel,
    output logic       marmux_sel,
    output logic       mdrmux_sel,
    output lc3b_aluop  aluop,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_byte_enable
);

    typedef enum logic [3:0] {
        fetch1, fetch2, fetch3, decode,
        s_add, s_and, s_not,
        br, br_taken,
        calc_addr, ldr1, ldr2, str1, str2
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= fetch1;
        else        state_q <= state_d;
    end

    assign mem_byte_enable = 2'b11;

    always_comb begin
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_regfile   = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_cc        = 1'b0;
        pcmux_sel      = 1'b0;
        storemux_sel   = 1'b0;
        alumux_sel     = 1'b0;
        regfilemux_sel = 1'b0;
        marmux_sel     = 1'b0;
        mdrmux_sel     = 1'b0;
        aluop          = alu_add;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        unique case (state_q)
            fetch1: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                load_pc    = 1'b1;
            end
            fetch2, ldr1: begin
                mem_read   = 1'b1;
                mdrmux_sel = 1'b1;
                load_mdr   = 1'b1;
            end
            fetch3: load_ir = 1'b1;
            s_add, s_and, s_not: begin
                aluop        = (state_q == s_add) ? alu_add :
                               (state_q == s_and) ? alu_and : alu_not;
                load_regfile = 1'b1;
                load_cc      = 1'b1;
            end
            br_taken: begin
                pcmux_sel = 1'b1;
                load_pc   = 1'b1;
            end
            calc_addr: begin
                alumux_sel = 1'b1;
                load_mar   = 1'b1;
            end
            ldr2: begin
                regfilemux_sel = 1'b1;
                load_regfile   = 1'b1;
                load_cc        = 1'b1;
            end
            str1: begin
                storemux_sel = 1'b1;
                aluop        = alu_pass;
                load_mdr     = 1'b1;
            end
            str2: mem_write = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            fetch1: state_d = fetch2;
            fetch2: if (mem_resp) state_d = fetch3;
            fetch3: state_d = decode;
            decode: begin
                case (opcode)
                    op_add:         state_d = s_add;
                    op_and:         state_d = s_and;
                    op_not:         state_d = s_not;
                    op_br:          state_d = br;
                    op_ldr, op_str: state_d = calc_addr;
                    default:        state_d = fetch1;
                endcase
            end
            s_add, s_and, s_not, br_taken, ldr2: state_d = fetch1;
            br: state_d = branch_enable ? br_taken : fetch1;
            // opcode is still the IR field here, so it picks the memory direction
            calc_addr: begin
                if (opcode == op_ldr)      state_d = ldr1;
                else if (opcode == op_str) state_d = str1;
                else                       state_d = fetch1;
            end
            ldr1: if (mem_resp) state_d = ldr2;
            str1: state_d = str2;
            str2: if (mem_resp) state_d = fetch1;
            default: state_d = fetch1;
        endcase
    end

endmodule
